// File: rtl/mux_scan_sampler_pkg.sv
// mux_scan_sampler_pkg: shared FSM encoding and settle-counter sizing for the scan sampler
package mux_scan_sampler_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;
  localparam int CNT_W = 4;
  localparam int SETTLE_MAX = 15;
endpackage

// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: steps mux select through every channel, samples after a settle time, returns the word via valid/ready
module mux_scan_sampler
  import mux_scan_sampler_pkg::*;
#(
  parameter int NCH = 8,
  parameter int SEL_W = 3,
  parameter int SETTLE = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_out,
  output logic [NCH-1:0]   data_out,
  output logic             data_valid,
  input  logic             data_ready
);
  localparam logic [SEL_W-1:0] FIRST = LSB_FIRST ? '0 : SEL_W'(NCH - 1);
  localparam logic [SEL_W-1:0] LAST  = LSB_FIRST ? SEL_W'(NCH - 1) : '0;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE);
  if (SEL_W != $clog2(NCH)) begin : g_bad_sel_w
    $error("mux_scan_sampler: SEL_W must equal clog2(NCH)");
  end
  if (SETTLE < 0 || SETTLE > SETTLE_MAX) begin : g_bad_settle
    $error("mux_scan_sampler: SETTLE out of range 0..15");
  end
  state_t           state;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sel        <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_SCAN;
          sel   <= FIRST;
          cnt   <= RELOAD;
          busy  <= 1'b1;
        end
        S_SCAN: if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else begin
          data_out[sel] <= mux_out;
          if (sel == LAST) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            data_valid <= 1'b1;
          end else begin
            sel <= LSB_FIRST ? sel + SEL_W'(1) : sel - SEL_W'(1);
            cnt <= RELOAD;
          end
        end
        S_DONE: if (data_ready) begin
          state      <= S_IDLE;
          data_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
